addsub_serial: RTL and testbench

Parametrised, multi-cycle add/subtract unit for the arithmetic lab datapath. It is the successor to the fixed 4-bit combinational subtractor. Width and digit size are generics, and add or subtract is selected per operation. Operands are captured on a start handshake and processed DIGIT bits per clock, LSB first. The (WIDTH+1)-bit result is presented with a one-cycle done pulse.

---
 rtl/addsub_if.sv | 22 ++
 rtl/addsub_serial.sv | 134 +++++++++++++
 tb/tb_addsub_serial.sv | 347 ++++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/addsub_if.sv
// Request/response bundle for addsub_serial: operand capture handshake and result.
// With ADDSUB_OVF_EN defined the bundle also carries the registered ovf flag.
interface addsub_if #(
    parameter int WIDTH = 16
);
    logic             start;
    logic             mode;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic             busy;
    logic             done;
    logic [WIDTH:0]   s;
`ifdef ADDSUB_OVF_EN
    logic             ovf;

    modport master (output start, mode, a, b, input busy, done, s, ovf);
    modport slave  (input start, mode, a, b, output busy, done, s, ovf);
`else
    modport master (output start, mode, a, b, input busy, done, s);
    modport slave  (input start, mode, a, b, output busy, done, s);
`endif
endinterface

// File: rtl/addsub_serial.sv
// Digit-serial add/subtract: WIDTH-bit operands, DIGIT bits per clock, LSB first.
// Optional signed-overflow output is enabled by defining ADDSUB_OVF_EN.

module addsub_bit (
    input  logic a,
    input  logic b,
    input  logic ci,
    output logic s,
    output logic co
);
    assign s  = a ^ b ^ ci;
    assign co = (a & b) | (ci & (a ^ b));
endmodule

module addsub_serial #(
    parameter int WIDTH = 16,
    parameter int DIGIT = 4
) (
    input  logic     ck,
    input  logic     rst_n,
    addsub_if.slave  bus
);
    localparam int N     = WIDTH / DIGIT;
    localparam int CNT_W = (N > 1) ? $clog2(N) : 1;

    typedef enum logic {IDLE, RUN} state_t;

    state_t             state_q, state_d;
    logic [WIDTH-1:0]   a_q, a_d;
    logic [WIDTH-1:0]   b_q, b_d;
    logic [WIDTH-1:0]   acc_q, acc_d;
    logic               cy_q, cy_d;
    logic               mode_q, mode_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic               done_q, done_d;
    logic [WIDTH:0]     s_q, s_d;
    logic               ovf_q, ovf_d;

    logic [DIGIT-1:0]       dig_s;
    logic [DIGIT:0]         cv;
    logic [WIDTH+DIGIT-1:0] acc_sh;
    logic                   last;

    // One ripple cell per bit of the current digit; cv[DIGIT-1] is the carry into the MSB on the last digit.
    assign cv[0] = cy_q;
    addsub_bit u_bit [DIGIT-1:0] (
        .a  (a_q[DIGIT-1:0]),
        .b  (b_q[DIGIT-1:0]),
        .ci (cv[DIGIT-1:0]),
        .s  (dig_s),
        .co (cv[DIGIT:1])
    );

    assign last   = (cnt_q == CNT_W'(N - 1));
    assign acc_sh = {dig_s, acc_q};

    always_comb begin
        state_d = state_q;
        a_d     = a_q;
        b_d     = b_q;
        acc_d   = acc_q;
        cy_d    = cy_q;
        mode_d  = mode_q;
        cnt_d   = cnt_q;
        done_d  = 1'b0;
        s_d     = s_q;
        ovf_d   = ovf_q;
        case (state_q)
            IDLE: begin
                if (bus.start) begin
                    a_d     = bus.a;
                    b_d     = bus.mode ? ~bus.b : bus.b;
                    mode_d  = bus.mode;
                    cy_d    = bus.mode;
                    cnt_d   = '0;
                    acc_d   = '0;
                    state_d = RUN;
                end
            end
            RUN: begin
                a_d   = a_q >> DIGIT;
                b_d   = b_q >> DIGIT;
                cy_d  = cv[DIGIT];
                acc_d = acc_sh[WIDTH+DIGIT-1:DIGIT];
                cnt_d = cnt_q + CNT_W'(1);
                if (last) begin
                    // Subtract reports borrow in the top bit, i.e. the inverted carry-out.
                    s_d     = {mode_q ^ cv[DIGIT], acc_sh[WIDTH+DIGIT-1:DIGIT]};
                    ovf_d   = cv[DIGIT] ^ cv[DIGIT-1];
                    done_d  = 1'b1;
                    cnt_d   = '0;
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge ck or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            a_q     <= '0;
            b_q     <= '0;
            acc_q   <= '0;
            cy_q    <= 1'b0;
            mode_q  <= 1'b0;
            cnt_q   <= '0;
            done_q  <= 1'b0;
            s_q     <= '0;
            ovf_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            a_q     <= a_d;
            b_q     <= b_d;
            acc_q   <= acc_d;
            cy_q    <= cy_d;
            mode_q  <= mode_d;
            cnt_q   <= cnt_d;
            done_q  <= done_d;
            s_q     <= s_d;
            ovf_q   <= ovf_d;
        end
    end

    assign bus.busy = (state_q == RUN);
    assign bus.done = done_q;
    assign bus.s    = s_q;
`ifdef ADDSUB_OVF_EN
    assign bus.ovf  = ovf_q;
`else
    logic ovf_unused;
    assign ovf_unused = ovf_q;
`endif
endmodule

// File: tb/tb_addsub_serial.sv
// Self-checking bench for addsub_serial: directed timing cases, exhaustive 4-bit sweep
// at three digit sizes, randomized 16-bit ops against an integer reference model.
module tb_addsub_serial;
    logic ck;
    logic rst_n;
    int   n_chk;
    int   n_fail;

    addsub_if #(.WIDTH(16)) if16 ();
    addsub_if #(.WIDTH(4))  if41 ();
    addsub_if #(.WIDTH(4))  if42 ();
    addsub_if #(.WIDTH(4))  if44 ();

    addsub_serial #(.WIDTH(16), .DIGIT(4)) u_dut16 (.ck(ck), .rst_n(rst_n), .bus(if16));
    addsub_serial #(.WIDTH(4),  .DIGIT(1)) u_dut41 (.ck(ck), .rst_n(rst_n), .bus(if41));
    addsub_serial #(.WIDTH(4),  .DIGIT(2)) u_dut42 (.ck(ck), .rst_n(rst_n), .bus(if42));
    addsub_serial #(.WIDTH(4),  .DIGIT(4)) u_dut44 (.ck(ck), .rst_n(rst_n), .bus(if44));

    initial ck = 1'b0;
    always #5 ck = ~ck;

    task automatic tick();
        @(posedge ck);
        #1;
    endtask

    function automatic logic [16:0] ref16(input logic m, input logic [15:0] av, input logic [15:0] bv);
        logic [16:0] xa, xb;
        xa = {1'b0, av};
        xb = {1'b0, bv};
        return m ? (xa - xb) : (xa + xb);
    endfunction

    function automatic logic ref_ovf(input logic m, input logic [15:0] av, input logic [15:0] bv);
        int sa, sb, r;
        sa = int'($signed(av));
        sb = int'($signed(bv));
        r  = m ? (sa - sb) : (sa + sb);
        return (r > 32767) || (r < -32768);
    endfunction

    // Runs one 16-bit operation and reports the first result, its edge after acceptance and pulse count.
    task automatic run16(input logic m, input logic [15:0] av, input logic [15:0] bv,
                         output logic [16:0] sv, output logic ov, output int lat, output int nd);
        if16.start = 1'b1;
        if16.mode  = m;
        if16.a     = av;
        if16.b     = bv;
        tick();
        if16.start = 1'b0;
        if16.mode  = ~m;
        if16.a     = 16'($urandom);
        if16.b     = 16'($urandom);
        lat = 0;
        nd  = 0;
        sv  = '0;
        ov  = 1'b0;
        for (int k = 1; k <= 7; k++) begin
            tick();
            if (if16.done) begin
                nd++;
                if (lat == 0) begin
                    lat = k;
                    sv  = if16.s;
`ifdef ADDSUB_OVF_EN
                    ov  = if16.ovf;
`endif
                end
            end
        end
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        #3;
        n_chk++;
        if ({if16.busy, if16.done, if16.s} !== 19'd0) begin
            n_fail++;
            $display("FAIL reset16: busy=%b done=%b s=%h, want all 0", if16.busy, if16.done, if16.s);
        end
        n_chk++;
        if ({if41.busy, if41.done, if41.s, if42.busy, if42.done, if42.s, if44.busy, if44.done, if44.s} !== 21'd0) begin
            n_fail++;
            $display("FAIL reset4: s41=%h s42=%h s44=%h busy/done not all 0", if41.s, if42.s, if44.s);
        end
`ifdef ADDSUB_OVF_EN
        n_chk++;
        if (if16.ovf !== 1'b0) begin
            n_fail++;
            $display("FAIL reset_ovf: ovf=%b want 0", if16.ovf);
        end
`endif
        tick();
        @(negedge ck);
        rst_n = 1'b1;
        tick();
    endtask

    task automatic test_sub_latency();
        int busy_cyc, nd, de;
        logic [16:0] sv;
        if16.start = 1'b1;
        if16.mode  = 1'b1;
        if16.a     = 16'h0003;
        if16.b     = 16'h0005;
        tick();
        if16.start = 1'b0;
        if16.mode  = 1'b0;
        if16.a     = 16'hAAAA;
        if16.b     = 16'h5555;
        busy_cyc = if16.busy ? 1 : 0;
        nd = 0; de = 0; sv = '0;
        for (int i = 1; i <= 8; i++) begin
            tick();
            if (i == 2) begin
                n_chk++;
                if (if16.s !== 17'h00000) begin
                    n_fail++;
                    $display("FAIL s_hold: s=%h during run, want 00000", if16.s);
                end
            end
            if (if16.busy) busy_cyc++;
            if (if16.done) begin
                nd++;
                de = i;
                sv = if16.s;
            end
        end
        n_chk++;
        if (busy_cyc !== 4) begin
            n_fail++;
            $display("FAIL busy_len: %0d cycles, want 4", busy_cyc);
        end
        n_chk++;
        if (nd !== 1 || de !== 4) begin
            n_fail++;
            $display("FAIL done_pulse: count=%0d edge=%0d, want 1 at 4", nd, de);
        end
        n_chk++;
        if (sv !== 17'h1FFFE) begin
            n_fail++;
            $display("FAIL sub_3_5: s=%h want 1fffe", sv);
        end
    endtask

    task automatic test_back_to_back();
        int e1, e2, nd;
        logic [16:0] s1, s2;
        e1 = 0; e2 = 0; nd = 0; s1 = '0; s2 = '0;
        if16.start = 1'b1;
        if16.mode  = 1'b0;
        if16.a     = 16'hFFFF;
        if16.b     = 16'h0001;
        tick();
        if16.a = 16'h0001;
        if16.b = 16'h0001;
        for (int i = 1; i <= 20; i++) begin
            tick();
            if (if16.done) begin
                nd++;
                if (nd == 1) begin e1 = i; s1 = if16.s; end
                if (nd == 2) begin e2 = i; s2 = if16.s; if16.start = 1'b0; end
            end
        end
        if16.start = 1'b0;
        n_chk++;
        if (s1 !== 17'h10000 || e1 !== 4) begin
            n_fail++;
            $display("FAIL b2b_first: s=%h edge=%0d, want 10000 at 4", s1, e1);
        end
        n_chk++;
        if (s2 !== 17'h00002 || (e2 - e1) !== 5) begin
            n_fail++;
            $display("FAIL b2b_second: s=%h gap=%0d, want 00002 gap 5", s2, e2 - e1);
        end
        n_chk++;
        if (nd !== 2 || if16.busy !== 1'b0) begin
            n_fail++;
            $display("FAIL b2b_count: dones=%0d busy=%b, want 2 and 0", nd, if16.busy);
        end
    endtask

    task automatic test_exhaustive4();
        int lat [3];
        int cnt [3];
        logic [4:0] got [3];
        logic [4:0] sv [3];
        logic [2:0] dn;
        logic [4:0] exp;
        int nreq [3];
        nreq[0] = 4; nreq[1] = 2; nreq[2] = 1;
        for (int m = 0; m < 2; m++) begin
            for (int p = 0; p < 256; p++) begin
                logic [3:0] av, bv;
                av = 4'(p >> 4);
                bv = 4'(p);
                exp = (m == 1) ? ({1'b0, av} - {1'b0, bv}) : ({1'b0, av} + {1'b0, bv});
                if41.start = 1'b1; if42.start = 1'b1; if44.start = 1'b1;
                if41.mode = m[0];  if42.mode = m[0];  if44.mode = m[0];
                if41.a = av; if42.a = av; if44.a = av;
                if41.b = bv; if42.b = bv; if44.b = bv;
                tick();
                if41.start = 1'b0; if42.start = 1'b0; if44.start = 1'b0;
                if41.a = ~av; if42.a = ~av; if44.a = ~av;
                for (int j = 0; j < 3; j++) begin
                    lat[j] = 0; cnt[j] = 0; got[j] = '0;
                end
                for (int k = 1; k <= 6; k++) begin
                    tick();
                    dn = {if44.done, if42.done, if41.done};
                    sv[0] = if41.s; sv[1] = if42.s; sv[2] = if44.s;
                    for (int j = 0; j < 3; j++) begin
                        if (dn[j]) begin
                            cnt[j]++;
                            if (lat[j] == 0) begin
                                lat[j] = k;
                                got[j] = sv[j];
                            end
                        end
                    end
                end
                for (int j = 0; j < 3; j++) begin
                    n_chk++;
                    if (got[j] !== exp || lat[j] !== nreq[j] || cnt[j] !== 1) begin
                        n_fail++;
                        $display("FAIL exh4_d%0d: mode=%0d a=%h b=%h s=%h lat=%0d n=%0d, want s=%h lat=%0d n=1",
                                 4 / nreq[j], m, av, bv, got[j], lat[j], cnt[j], exp, nreq[j]);
                    end
                end
            end
        end
    endtask

    task automatic test_random16();
        logic [16:0] sv;
        logic ov;
        int lat, nd;
        for (int i = 0; i < 200; i++) begin
            logic m;
            logic [15:0] av, bv;
            m  = 1'($urandom_range(0, 1));
            av = 16'($urandom);
            bv = 16'($urandom);
            run16(m, av, bv, sv, ov, lat, nd);
            n_chk++;
            if (sv !== ref16(m, av, bv) || lat !== 4 || nd !== 1) begin
                n_fail++;
                $display("FAIL rand16: mode=%b a=%h b=%h s=%h lat=%0d n=%0d, want s=%h lat=4 n=1",
                         m, av, bv, sv, lat, nd, ref16(m, av, bv));
            end
`ifdef ADDSUB_OVF_EN
            n_chk++;
            if (ov !== ref_ovf(m, av, bv)) begin
                n_fail++;
                $display("FAIL rand_ovf: mode=%b a=%h b=%h ovf=%b want %b", m, av, bv, ov, ref_ovf(m, av, bv));
            end
`endif
        end
    endtask

`ifdef ADDSUB_OVF_EN
    task automatic test_ovf();
        logic [16:0] sv;
        logic ov;
        int lat, nd;
        run16(1'b0, 16'h7FFF, 16'h0001, sv, ov, lat, nd);
        n_chk++;
        if (ov !== 1'b1 || sv !== 17'h08000) begin
            n_fail++;
            $display("FAIL ovf_add: ovf=%b s=%h, want 1 08000", ov, sv);
        end
        run16(1'b1, 16'h8000, 16'h0001, sv, ov, lat, nd);
        n_chk++;
        if (ov !== 1'b1) begin
            n_fail++;
            $display("FAIL ovf_sub: ovf=%b want 1", ov);
        end
        run16(1'b1, 16'h0005, 16'h0003, sv, ov, lat, nd);
        n_chk++;
        if (ov !== 1'b0 || sv !== 17'h00002) begin
            n_fail++;
            $display("FAIL ovf_none: ovf=%b s=%h, want 0 00002", ov, sv);
        end
    endtask
`endif

    task automatic test_reset_mid();
        logic [16:0] sv;
        logic ov;
        int lat, nd;
        run16(1'b0, 16'h0007, 16'h0001, sv, ov, lat, nd);
        if16.start = 1'b1;
        if16.mode  = 1'b0;
        if16.a     = 16'h1234;
        if16.b     = 16'h0101;
        tick();
        if16.start = 1'b0;
        tick();
        @(posedge ck);
        rst_n = 1'b0;
        #1;
        n_chk++;
        if (if16.busy !== 1'b0 || if16.done !== 1'b0 || if16.s !== 17'h00000) begin
            n_fail++;
            $display("FAIL rst_mid: busy=%b done=%b s=%h, want 0 0 00000", if16.busy, if16.done, if16.s);
        end
        tick();
        @(negedge ck);
        rst_n = 1'b1;
        nd = 0;
        for (int i = 0; i < 10; i++) begin
            tick();
            if (if16.done || if16.busy) nd++;
        end
        n_chk++;
        if (nd !== 0) begin
            n_fail++;
            $display("FAIL rst_abort: %0d cycles with busy/done after release, want 0", nd);
        end
        run16(1'b1, 16'h0007, 16'h0002, sv, ov, lat, nd);
        n_chk++;
        if (sv !== 17'h00005 || lat !== 4 || nd !== 1) begin
            n_fail++;
            $display("FAIL rst_next: s=%h lat=%0d n=%0d, want 00005 lat=4 n=1", sv, lat, nd);
        end
    endtask

    initial begin
        n_chk  = 0;
        n_fail = 0;
        if16.start = 1'b0; if16.mode = 1'b0; if16.a = '0; if16.b = '0;
        if41.start = 1'b0; if41.mode = 1'b0; if41.a = '0; if41.b = '0;
        if42.start = 1'b0; if42.mode = 1'b0; if42.a = '0; if42.b = '0;
        if44.start = 1'b0; if44.mode = 1'b0; if44.a = '0; if44.b = '0;
        test_reset();
        test_sub_latency();
        test_back_to_back();
        test_exhaustive4();
        test_random16();
`ifdef ADDSUB_OVF_EN
        test_ovf();
`endif
        test_reset_mid();
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
